hyperbus_ddr_in_assembler: RTL
==============================

Name: hyperbus_ddr_in_assembler

Overview:
Receive-side counterpart of the HyperBus DDR output path. It takes byte pairs already captured by the PHY from both edges of RWDS and assembles them into 32-bit words. A burst counter tracks the expected read length, and the words are buffered in a small FIFO. Words leave on a valid/ready stream towards the uDMA RX channel. The PHY side cannot be stalled mid-burst, so overflow is detected and flagged, never back-pressured.

Parameters:
FIFO_DEPTH, 4, number of 32-bit word entries in the output FIFO (power of two, ≥2)
LEN_W, 16, width of the burst length, in 16-bit halfwords

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse: arm a new read burst
len_i  in  LEN_W  halfwords expected in the burst; sampled on start_i
clear_i  in  1  synchronous abort: flush FIFO and return to IDLE
rx_valid_i  in  1  one DDR beat captured this cycle
rx_d0_i  in  8  byte captured on RWDS rising edge (upper byte of halfword)
rx_d1_i  in  8  byte captured on RWDS falling edge (lower byte of halfword)
data_o  out  32  assembled word; first halfword of the word in [15:0]
strb_o  out  4  byte enables for data_o
valid_o  out  1  FIFO head valid
ready_i  in  1  consumer accepts head
last_o  out  1  head word is the final word of the burst
busy_o  out  1  burst in progress (state RECV)
done_o  out  1  one-cycle pulse after the final word is enqueued
overflow_o  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters 0; FIFO empty.
- Halfword = {rx_d0_i, rx_d1_i}.
- Even beat fills the holding register [15:0]. Odd beat completes the word {hw, hold} with strb 4'hF, and the word is pushed the same cycle.
- FSM states:
  - IDLE: start_i with len_i>0 -> RECV, remaining = len_i, half-word phase = 0, overflow_o cleared.
  - IDLE: start_i with len_i==0 -> no state change, done_o pulses next cycle.
  - RECV: each rx_valid_i decrements remaining.
  - RECV: when remaining reaches 0, the final word is pushed with last=1. If len is odd, the final word is {16'h0, hw} with strb 4'h3. Then -> IDLE and done_o pulses in the cycle after the push.
- rx_valid_i in IDLE is ignored.
- start_i while in RECV is ignored.
- clear_i has priority over every event:
  - FIFO emptied, state -> IDLE, counters zeroed, overflow_o cleared.
  - valid_o is 0 the next cycle.
  - No done_o pulse.
- Latency: a word pushed in cycle N is visible at data_o/valid_o in cycle N+1 (registered FIFO, no fall-through).
- Pop when valid_o && ready_i.
  - Simultaneous push and pop with the FIFO full is accepted and is not an overflow.
- Push while full without a pop:
  - Word dropped; overflow_o set and held until the next start_i or clear_i.
  - Burst counting continues.
  - If the dropped word was the last word, no last_o is ever presented, but done_o still pulses.
- data_o, strb_o and last_o are stable while valid_o && !ready_i.
- Pointer wrap uses an extra MSB to distinguish full from empty.
- Reset asserted mid-burst: everything returns to the reset values immediately.

Decomposition:
- Shared package hyperbus_pkg:
  - FSM state enum (IDLE, RECV)
  - fifo entry struct {data[31:0], strb[3:0], last}
  - constant HALFWORD_W=16
- Sub-module hyperbus_rx_fifo (synchronous, registered output, push/pop/full/empty/flush), instantiated once.
- The FSM, counter and word assembly stay in the top module.

Test Plan:
- Even burst: start len=4, beats AA/BB, CC/DD, 11/22, 33/44, ready_i=1.
  - Words CCDD_AABB strb F last 0, then 3344_1122 strb F last 1.
  - done_o one cycle after the second push.
- Odd burst: len=3, beats 01/02, 03/04, 05/06.
  - Words 0304_0102 strb F, then 0000_0506 strb 3 last 1.
- Backpressure/overflow (FIFO_DEPTH=4): ready_i=0, len=10 (5 words).
  - First 4 words held in order; 5th dropped; overflow_o=1; done_o pulses; no last_o.
  - Raise ready_i: 4 words drain in order.
  - Next start_i clears overflow_o.
- Full with simultaneous pop: FIFO full, ready_i=1 in the cycle the next word completes.
  - No overflow; ordering preserved.
- Abort: clear_i after 3 beats of len=8.
  - valid_o=0 next cycle, busy_o=0, no done_o.
  - Following burst len=2, beats 11/22, 33/44 -> single word 3344_1122 last 1.
- Edge cases:
  - len=0 -> done_o pulse only, no word.
  - rx_valid_i in IDLE -> no word.
  - start_i during RECV ignored: the burst completes with the original length.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus DDR receive path: FSM states and the
// word record carried through the RX FIFO.
package hyperbus_pkg;

  localparam int HALFWORD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } fifo_entry_t;

endpackage

// File: rtl/hyperbus_rx_fifo.sv
// Word FIFO between the DDR assembler and the uDMA RX stream. Head is read
// straight from registered storage, so a push becomes visible one cycle later.
module hyperbus_rx_fifo
  import hyperbus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush,
  input  logic        push,
  input  fifo_entry_t wdata,
  input  logic        pop,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  logic [AW:0] wptr, rptr;
  fifo_entry_t mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/hyperbus_ddr_in_assembler.sv
// Assembles PHY-captured DDR halfwords into 32-bit words for the uDMA RX
// channel. The PHY cannot be stalled, so a full FIFO drops words and flags it.
module hyperbus_ddr_in_assembler
  import hyperbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             clear_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_d0_i,
  input  logic [7:0]       rx_d1_i,
  output logic [31:0]      data_o,
  output logic [3:0]       strb_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  phase_q, phase_d;
  logic [HALFWORD_W-1:0] hold_q, hold_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [HALFWORD_W-1:0] hw;
  logic                  word_push, fifo_pop, fifo_full, fifo_empty;
  fifo_entry_t           word, head;

  assign hw       = {rx_d0_i, rx_d1_i};
  assign fifo_pop = valid_o && ready_i;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    word_push = 1'b0;
    word      = '0;
    if (clear_i) begin
      state_d = IDLE;
      rem_d   = '0;
      phase_d = 1'b0;
      hold_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            ovf_d = 1'b0;
            if (len_i != '0) begin
              state_d = RECV;
              rem_d   = len_i;
              phase_d = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RECV: begin
          if (rx_valid_i) begin
            rem_d   = rem_q - 1'b1;
            phase_d = ~phase_q;
            if (!phase_q) hold_d = hw;
            // Odd phase completes a word; a final even beat emits a half word.
            if (phase_q || rem_q == LEN_W'(1)) begin
              word_push = 1'b1;
              word.data = phase_q ? {hw, hold_q} : {16'h0, hw};
              word.strb = phase_q ? 4'hF : 4'h3;
              word.last = (rem_q == LEN_W'(1));
            end
            if (rem_q == LEN_W'(1)) begin
              state_d = IDLE;
              phase_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (word_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  hyperbus_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (clear_i),
    .push   (word_push),
    .wdata  (word),
    .pop    (fifo_pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign valid_o    = !fifo_empty;
  assign data_o     = head.data;
  assign strb_o     = head.strb;
  assign last_o     = head.last;
  assign busy_o     = (state_q == RECV);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule
